// File: rtl/pt_pkg.sv
// Shared types and constants for the Pan-Tompkins decision stage.
package pt_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_RUN  = 2'd1,
        S_SB   = 2'd2
    } pt_state_e;

    // RR history depth and its log2
    localparam int unsigned RR_DEPTH      = 8;
    localparam int unsigned RR_DEPTH_LOG2 = 3;

    // Guard bits on RR arithmetic so the limits cannot overflow
    localparam int unsigned RR_GUARD = 3;

    // lo   = avg - avg/16
    // hi   = avg + avg/8 + avg/32
    // miss = avg + avg/2 + avg/8 + avg/32
    localparam int unsigned LO_SHIFT     = 4;
    localparam int unsigned HI_SHIFT_A   = 3;
    localparam int unsigned HI_SHIFT_B   = 5;
    localparam int unsigned MISS_SHIFT_A = 1;
    localparam int unsigned MISS_SHIFT_B = 3;
    localparam int unsigned MISS_SHIFT_C = 5;

endpackage

// File: rtl/rr_averager.sv
// Eight-deep RR interval history with running sum; produces the average and
// the lo/hi/miss limits derived from the current (pre-push) average.
module rr_averager
    import pt_pkg::*;
#(
    parameter int unsigned RR_W    = 12,
    parameter int unsigned RR_INIT = 160
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [RR_W-1:0]          rr,
    output logic [RR_W-1:0]          rr_avg,
    output logic [RR_W+RR_GUARD-1:0] rr_lo_c,
    output logic [RR_W+RR_GUARD-1:0] rr_hi_c,
    output logic [RR_W+RR_GUARD-1:0] rr_miss_c
);

    localparam int unsigned SUM_W = RR_W + RR_GUARD;

    logic [RR_W-1:0]  hist [RR_DEPTH];
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
    logic [SUM_W-1:0] avg_x;

    // Running sum: drop the oldest slot, add the new interval
    assign sum_d = sum_q - SUM_W'(hist[RR_DEPTH-1]) + SUM_W'(rr);

    // History shift register, sum and registered average
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RR_DEPTH; i++) begin
                hist[i] <= RR_W'(RR_INIT);
            end
            sum_q  <= SUM_W'(RR_INIT * RR_DEPTH);
            rr_avg <= RR_W'(RR_INIT);
        end else if (push) begin
            hist[0] <= rr;
            for (int i = 1; i < RR_DEPTH; i++) begin
                hist[i] <= hist[i-1];
            end
            sum_q  <= sum_d;
            rr_avg <= RR_W'(sum_d >> RR_DEPTH_LOG2);
        end
    end

    // Acceptance and searchback limits from the current average
    always_comb begin
        avg_x     = SUM_W'(rr_avg);
        rr_lo_c   = avg_x - (avg_x >> LO_SHIFT);
        rr_hi_c   = avg_x + (avg_x >> HI_SHIFT_A) + (avg_x >> HI_SHIFT_B);
        rr_miss_c = avg_x + (avg_x >> MISS_SHIFT_A) + (avg_x >> MISS_SHIFT_B)
                  + (avg_x >> MISS_SHIFT_C);
    end

endmodule

// File: rtl/qrs_peak_classifier.sv
// Pan-Tompkins decision stage: learning phase, peak classification against
// adaptive thresholds, RR bookkeeping, refractory blanking and searchback.
// Build option: define QRS_SEARCHBACK_EN to include candidate tracking and
// the S_SB recovery state; without it missed beats are not recovered.
module qrs_peak_classifier
    import pt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned RR_W       = 12,
    parameter int unsigned INIT_LOG2  = 3,
    parameter int unsigned REFRACT    = 40,
    parameter int unsigned RR_INIT    = 160
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         peak_valid,
    input  logic signed [DATA_WIDTH-1:0] peak_i,
    input  logic signed [DATA_WIDTH-1:0] peak_f,
    input  logic signed [DATA_WIDTH-1:0] thri_1,
    input  logic signed [DATA_WIDTH-1:0] thri_2,
    input  logic signed [DATA_WIDTH-1:0] thrf_1,
    input  logic signed [DATA_WIDTH-1:0] thrf_2,
    output logic signed [DATA_WIDTH-1:0] peak_i_o,
    output logic signed [DATA_WIDTH-1:0] peak_f_o,
    output logic signed [DATA_WIDTH-1:0] peak_i_sb,
    output logic signed [DATA_WIDTH-1:0] peak_f_sb,
    output logic signed [DATA_WIDTH-1:0] peak_i_max,
    output logic signed [DATA_WIDTH-1:0] peak_i_mean,
    output logic signed [DATA_WIDTH-1:0] peak_f_max,
    output logic signed [DATA_WIDTH-1:0] peak_f_mean,
    output logic                         init,
    output logic                         npu,
    output logic                         spu,
    output logic                         flag,
    output logic                         peak_selector,
    output logic [RR_W-1:0]              rr_avg
);

    localparam int unsigned SUM_W = DATA_WIDTH + INIT_LOG2;
    localparam int unsigned LIM_W = RR_W + RR_GUARD;

    pt_state_e                   state_q, state_d;
    logic [INIT_LOG2-1:0]        cnt_q, cnt_d;
    logic signed [SUM_W-1:0]     sum_i_q, sum_i_d, sum_f_q, sum_f_d;
    logic signed [DATA_WIDTH-1:0] max_i_q, max_i_d, max_f_q, max_f_d;
    logic [RR_W-1:0]             since_q, since_d, since_inc_c;

    logic signed [DATA_WIDTH-1:0] peak_i_o_d, peak_f_o_d;
    logic signed [DATA_WIDTH-1:0] peak_i_max_d, peak_i_mean_d;
    logic signed [DATA_WIDTH-1:0] peak_f_max_d, peak_f_mean_d;
    logic                         init_d, npu_d, spu_d, flag_d;

    logic                         qual_c;
    logic                         rr_push_c;
    logic [RR_W-1:0]              rr_val_c;
    logic [LIM_W-1:0]             rr_ext_c;
    logic [LIM_W-1:0]             rr_lo_c, rr_hi_c, rr_miss_c;
    logic                         rr_flag_c;

`ifdef QRS_SEARCHBACK_EN
    logic                         cand_q, cand_d;
    logic signed [DATA_WIDTH-1:0] sb_i_d, sb_f_d;
    logic [RR_W-1:0]              sb_pos_q, sb_pos_d;
    logic                         sel_d;
`else
    logic                         unused_sb_c;
`endif

    assign qual_c      = en & peak_valid;
    assign since_inc_c = (&since_q) ? since_q : since_q + RR_W'(1);

    // RR for the current spu: searchback position in S_SB, else the live count
`ifdef QRS_SEARCHBACK_EN
    assign rr_val_c = (state_q == S_SB) ? sb_pos_q : since_q;
`else
    assign rr_val_c    = since_q;
    assign unused_sb_c = ^{thri_2, thrf_2, rr_miss_c};
`endif

    // Irregular-RR flag against the limits of the pre-push average
    assign rr_ext_c  = LIM_W'(rr_val_c);
    assign rr_flag_c = (rr_ext_c < rr_lo_c) | (rr_ext_c > rr_hi_c);

    rr_averager #(
        .RR_W    (RR_W),
        .RR_INIT (RR_INIT)
    ) u_rr_averager (
        .clk       (clk),
        .rst       (rst),
        .push      (rr_push_c),
        .rr        (rr_val_c),
        .rr_avg    (rr_avg),
        .rr_lo_c   (rr_lo_c),
        .rr_hi_c   (rr_hi_c),
        .rr_miss_c (rr_miss_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sum_i_d       = sum_i_q;
        sum_f_d       = sum_f_q;
        max_i_d       = max_i_q;
        max_f_d       = max_f_q;
        since_d       = since_q;
        peak_i_o_d    = peak_i_o;
        peak_f_o_d    = peak_f_o;
        peak_i_max_d  = peak_i_max;
        peak_i_mean_d = peak_i_mean;
        peak_f_max_d  = peak_f_max;
        peak_f_mean_d = peak_f_mean;
        init_d        = 1'b0;
        npu_d         = 1'b0;
        spu_d         = 1'b0;
        flag_d        = 1'b0;
        rr_push_c     = 1'b0;
`ifdef QRS_SEARCHBACK_EN
        cand_d        = cand_q;
        sb_i_d        = peak_i_sb;
        sb_f_d        = peak_f_sb;
        sb_pos_d      = sb_pos_q;
        sel_d         = 1'b0;
`endif

        case (state_q)
            S_INIT: begin
                if (qual_c) begin
                    peak_i_o_d = peak_i;
                    peak_f_o_d = peak_f;
                    sum_i_d    = sum_i_q + SUM_W'(peak_i);
                    sum_f_d    = sum_f_q + SUM_W'(peak_f);
                    if ((cnt_q == '0) || (peak_i > max_i_q)) max_i_d = peak_i;
                    if ((cnt_q == '0) || (peak_f > max_f_q)) max_f_d = peak_f;
                    cnt_d = cnt_q + INIT_LOG2'(1);
                    if (cnt_q == '1) begin
                        init_d        = 1'b1;
                        peak_i_max_d  = max_i_d;
                        peak_f_max_d  = max_f_d;
                        peak_i_mean_d = DATA_WIDTH'(sum_i_d >>> INIT_LOG2);
                        peak_f_mean_d = DATA_WIDTH'(sum_f_d >>> INIT_LOG2);
                        sum_i_d       = '0;
                        sum_f_d       = '0;
                        since_d       = '0;
                        state_d       = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (en) since_d = since_inc_c;
                if (qual_c) begin
                    peak_i_o_d = peak_i;
                    peak_f_o_d = peak_f;
                    if (since_q < RR_W'(REFRACT)) begin
                        npu_d = 1'b1;
                    end else if ((peak_i > thri_1) && (peak_f > thrf_1)) begin
                        spu_d     = 1'b1;
                        flag_d    = rr_flag_c;
                        rr_push_c = 1'b1;
                        since_d   = '0;
`ifdef QRS_SEARCHBACK_EN
                        cand_d    = 1'b0;
`endif
                    end else begin
                        npu_d = 1'b1;
`ifdef QRS_SEARCHBACK_EN
                        if ((peak_i > thri_2) && (peak_f > thrf_2) &&
                            (!cand_q || (peak_i > peak_i_sb))) begin
                            cand_d   = 1'b1;
                            sb_i_d   = peak_i;
                            sb_f_d   = peak_f;
                            sb_pos_d = since_q;
                        end
`endif
                    end
                end
`ifdef QRS_SEARCHBACK_EN
                // Miss limit reached with a candidate: hold the count for recovery
                else if (en && cand_q && (LIM_W'(since_q) >= rr_miss_c)) begin
                    since_d = since_q;
                    state_d = S_SB;
                end
`endif
            end

`ifdef QRS_SEARCHBACK_EN
            S_SB: begin
                spu_d      = 1'b1;
                sel_d      = 1'b1;
                flag_d     = rr_flag_c;
                rr_push_c  = 1'b1;
                peak_i_o_d = peak_i_sb;
                peak_f_o_d = peak_f_sb;
                since_d    = since_q - sb_pos_q;
                cand_d     = 1'b0;
                state_d    = S_RUN;
            end
`endif

            default: state_d = S_INIT;
        endcase
    end

    // State, learning datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            sum_i_q     <= '0;
            sum_f_q     <= '0;
            max_i_q     <= '0;
            max_f_q     <= '0;
            since_q     <= '0;
            peak_i_o    <= '0;
            peak_f_o    <= '0;
            peak_i_max  <= '0;
            peak_i_mean <= '0;
            peak_f_max  <= '0;
            peak_f_mean <= '0;
            init        <= 1'b0;
            npu         <= 1'b0;
            spu         <= 1'b0;
            flag        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sum_i_q     <= sum_i_d;
            sum_f_q     <= sum_f_d;
            max_i_q     <= max_i_d;
            max_f_q     <= max_f_d;
            since_q     <= since_d;
            peak_i_o    <= peak_i_o_d;
            peak_f_o    <= peak_f_o_d;
            peak_i_max  <= peak_i_max_d;
            peak_i_mean <= peak_i_mean_d;
            peak_f_max  <= peak_f_max_d;
            peak_f_mean <= peak_f_mean_d;
            init        <= init_d;
            npu         <= npu_d;
            spu         <= spu_d;
            flag        <= flag_d;
        end
    end

`ifdef QRS_SEARCHBACK_EN
    // Searchback candidate and selector registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_q        <= 1'b0;
            sb_pos_q      <= '0;
            peak_i_sb     <= '0;
            peak_f_sb     <= '0;
            peak_selector <= 1'b0;
        end else begin
            cand_q        <= cand_d;
            sb_pos_q      <= sb_pos_d;
            peak_i_sb     <= sb_i_d;
            peak_f_sb     <= sb_f_d;
            peak_selector <= sel_d;
        end
    end
`else
    assign peak_i_sb     = '0;
    assign peak_f_sb     = '0;
    assign peak_selector = 1'b0;
`endif

endmodule

// File: tb/tb_qrs_peak_classifier.sv
// Directed bench for qrs_peak_classifier: learning, normal and refractory
// peaks, irregular RR, searchback recovery and reset during searchback.
`timescale 1ns/1ps
module tb_qrs_peak_classifier;
    import pt_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 peak_valid;
    logic signed [DW-1:0] peak_i, peak_f;
    logic signed [DW-1:0] thri_1, thri_2, thrf_1, thrf_2;
    logic signed [DW-1:0] peak_i_o, peak_f_o, peak_i_sb, peak_f_sb;
    logic signed [DW-1:0] peak_i_max, peak_i_mean, peak_f_max, peak_f_mean;
    logic                 init, npu, spu, flag, peak_selector;
    logic [RW-1:0]        rr_avg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    qrs_peak_classifier #(
        .DATA_WIDTH (DW),
        .RR_W       (RW),
        .INIT_LOG2  (3),
        .REFRACT    (40),
        .RR_INIT    (160)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .peak_valid    (peak_valid),
        .peak_i        (peak_i),
        .peak_f        (peak_f),
        .thri_1        (thri_1),
        .thri_2        (thri_2),
        .thrf_1        (thrf_1),
        .thrf_2        (thrf_2),
        .peak_i_o      (peak_i_o),
        .peak_f_o      (peak_f_o),
        .peak_i_sb     (peak_i_sb),
        .peak_f_sb     (peak_f_sb),
        .peak_i_max    (peak_i_max),
        .peak_i_mean   (peak_i_mean),
        .peak_f_max    (peak_f_max),
        .peak_f_mean   (peak_f_mean),
        .init          (init),
        .npu           (npu),
        .spu           (spu),
        .flag          (flag),
        .peak_selector (peak_selector),
        .rr_avg        (rr_avg)
    );

    task automatic chk(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Present one peak in the current cycle; returns just after the capturing edge
    task automatic drive_peak(input int pi, input int pf);
        @(negedge clk);
        peak_valid = 1'b1;
        peak_i     = DW'(pi);
        peak_f     = DW'(pf);
        @(posedge clk);
        #1;
        peak_valid = 1'b0;
    endtask

    task automatic skip(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; peak_valid = 1'b0;
        peak_i = '0; peak_f = '0;
        thri_1 = 16'sd300; thrf_1 = 16'sd300;
        thri_2 = 16'sd150; thrf_2 = 16'sd150;

        // Reset state
        skip(2);
        chk("rst_init", init, 0);
        chk("rst_npu", npu, 0);
        chk("rst_spu", spu, 0);
        chk("rst_flag", flag, 0);
        chk("rst_sel", peak_selector, 0);
        chk("rst_peak_i_o", peak_i_o, 0);
        chk("rst_rr_avg", rr_avg, 160);
        @(negedge clk);
        rst = 1'b0;

        // Learning: 8 peaks, init on the last one
        for (int k = 1; k <= 8; k++) begin
            drive_peak(100 * k, 50 * k);
            chk("learn_npu", npu, 0);
            chk("learn_spu", spu, 0);
            if (k < 8) begin
                chk("learn_init_low", init, 0);
                skip(1);
            end
        end
        chk("learn_init", init, 1);
        chk("learn_max_i", peak_i_max, 800);
        chk("learn_mean_i", peak_i_mean, 450);
        chk("learn_max_f", peak_f_max, 400);
        chk("learn_mean_f", peak_f_mean, 225);

        // Normal beat at since_qrs = 160
        skip(160);
        drive_peak(500, 500);
        chk("beat_spu", spu, 1);
        chk("beat_npu", npu, 0);
        chk("beat_init", init, 0);
        chk("beat_flag", flag, 0);
        chk("beat_sel", peak_selector, 0);
        chk("beat_peak_i_o", peak_i_o, 500);
        chk("beat_rr_avg", rr_avg, 160);

        // Refractory: strong peak 20 samples after QRS
        skip(20);
        drive_peak(900, 900);
        chk("refr_npu", npu, 1);
        chk("refr_spu", spu, 0);

        // Noise peak at sample 100 becomes a searchback candidate
        skip(79);
        drive_peak(200, 200);
        chk("noise_npu", npu, 1);
        chk("noise_spu", spu, 0);
        skip(165);
        chk("sb_pre_spu", spu, 0);
        skip(1);
`ifdef QRS_SEARCHBACK_EN
        chk("sb_spu", spu, 1);
        chk("sb_npu", npu, 0);
        chk("sb_sel", peak_selector, 1);
        chk("sb_peak_i_o", peak_i_o, 200);
        chk("sb_peak_f_o", peak_f_o, 200);
        chk("sb_peak_i_sb", peak_i_sb, 200);
        chk("sb_flag", flag, 1);
        chk("sb_rr_avg", rr_avg, 152);
        chk("sb_since", dut.since_q, 165);
`else
        chk("nosb_spu", spu, 0);
        chk("nosb_sel", peak_selector, 0);
        chk("nosb_peak_i_sb", peak_i_sb, 0);
        chk("nosb_rr_avg", rr_avg, 160);
`endif
        skip(1);
        chk("post_sb_spu", spu, 0);
        chk("post_sb_sel", peak_selector, 0);

        // Next beat: RR 170 after recovery, or 272 with no recovery
        skip(4);
        drive_peak(500, 500);
        chk("beat2_spu", spu, 1);
`ifdef QRS_SEARCHBACK_EN
        chk("beat2_flag", flag, 0);
        chk("beat2_rr_avg", rr_avg, 153);
`else
        chk("beat2_flag", flag, 1);
        chk("beat2_rr_avg", rr_avg, 174);
`endif

        // Second candidate, then reset while in S_SB
        skip(100);
        drive_peak(200, 200);
        chk("noise2_npu", npu, 1);
        skip(152);
`ifdef QRS_SEARCHBACK_EN
        chk("in_sb_state", int'(dut.state_q), int'(S_SB));
`endif
        rst = 1'b1;
        #1;
        chk("mid_rst_spu", spu, 0);
        chk("mid_rst_npu", npu, 0);
        chk("mid_rst_sel", peak_selector, 0);
        chk("mid_rst_flag", flag, 0);
        chk("mid_rst_peak_i_o", peak_i_o, 0);
        chk("mid_rst_peak_i_sb", peak_i_sb, 0);
        chk("mid_rst_max_i", peak_i_max, 0);
        chk("mid_rst_rr_avg", rr_avg, 160);
        chk("mid_rst_state", int'(dut.state_q), int'(S_INIT));
        skip(2);
        @(negedge clk);
        rst = 1'b0;

        // Learning repeats after reset
        for (int k = 1; k <= 8; k++) begin
            drive_peak(10 * k, 20 * k);
            chk("relearn_spu", spu, 0);
            chk("relearn_npu", npu, 0);
            if (k < 8) begin
                chk("relearn_init_low", init, 0);
                skip(1);
            end
        end
        chk("relearn_init", init, 1);
        chk("relearn_max_i", peak_i_max, 80);
        chk("relearn_mean_i", peak_i_mean, 45);
        chk("relearn_max_f", peak_f_max, 160);
        chk("relearn_mean_f", peak_f_mean, 90);
        chk("relearn_rr_avg", rr_avg, 160);
        skip(1);
        chk("relearn_init_drop", init, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
